// File: rtl/vc_arb_packet_mux_if.sv
// Handshake bundle for the packet-aware arbiter mux: N flit inputs, one flit output.
interface vc_arb_packet_mux_if #(
  parameter int p_num_reqs = 2,
  parameter int p_nbits    = 32
);
  logic [p_num_reqs-1:0]         in_val;
  logic [p_num_reqs-1:0]         in_rdy;
  logic [p_num_reqs*p_nbits-1:0] in_msg;
  logic [p_num_reqs-1:0]         in_last;
  logic                          out_val;
  logic                          out_rdy;
  logic [p_nbits-1:0]            out_msg;
  logic                          out_last;

  modport master (
    output in_val, in_msg, in_last, out_rdy,
    input  in_rdy, out_val, out_msg, out_last
  );

  modport slave (
    input  in_val, in_msg, in_last, out_rdy,
    output in_rdy, out_val, out_msg, out_last
  );
endinterface

// File: rtl/vc_arb_packet_mux.sv
// Round-robin packet mux: locks onto an input until its tail flit, 2-entry output FIFO.
// Latency 1 cycle minimum; in_rdy drops when the FIFO is full, independent of out_rdy.
module vc_arb_packet_mux #(
  parameter int p_num_reqs = 2,
  parameter int p_nbits    = 32
) (
  input logic              clk,
  input logic              reset,
  vc_arb_packet_mux_if.slave bus
);
  localparam int IW = $clog2(p_num_reqs);

  logic [1:0]            count;
  logic [p_nbits-1:0]    msg0, msg1;
  logic                  last0, last1;
  logic [p_num_reqs-1:0] prio;
  logic                  lock;
  logic [IW-1:0]         lock_id;

  logic [p_num_reqs-1:0] grant, rdy, acc;
  logic                  found;
  logic                  space, deq, acc_any, acc_last, wr_head;
  logic [IW-1:0]         acc_idx;
  logic [p_nbits-1:0]    acc_msg;

  assign space        = (count != 2'd2);
  assign deq          = (count != 2'd0) && bus.out_rdy;
  assign bus.out_val  = (count != 2'd0);
  assign bus.out_msg  = msg0;
  assign bus.out_last = last0;

  // Circular scan starting at the one-hot priority position.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < p_num_reqs; k++) begin
      for (int j = 0; j < p_num_reqs; j++) begin
        if (!found && prio[j] && bus.in_val[(j + k) % p_num_reqs]) begin
          grant[(j + k) % p_num_reqs] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdy = '0;
    if (reset) begin
      if (lock) rdy[lock_id] = space;
      else      rdy = grant & {p_num_reqs{space}};
    end
  end

  assign bus.in_rdy = rdy;
  assign acc        = bus.in_val & rdy;
  assign acc_any    = |acc;

  always_comb begin
    acc_idx  = '0;
    acc_msg  = '0;
    acc_last = 1'b0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (acc[i]) begin
        acc_idx  = IW'(i);
        acc_msg  = bus.in_msg[i*p_nbits +: p_nbits];
        acc_last = bus.in_last[i];
      end
    end
  end

  // Incoming flit lands in the head slot when the FIFO is empty or is emptying this cycle.
  assign wr_head = (count == 2'd0) || deq;

  always_ff @(posedge clk) begin
    if (deq) begin
      msg0  <= msg1;
      last0 <= last1;
    end
    if (acc_any) begin
      if (wr_head) begin
        msg0  <= acc_msg;
        last0 <= acc_last;
      end else begin
        msg1  <= acc_msg;
        last1 <= acc_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= 2'd0;
      lock    <= 1'b0;
      lock_id <= '0;
      prio    <= {{(p_num_reqs-1){1'b0}}, 1'b1};
    end else begin
      count <= count + {1'b0, acc_any} - {1'b0, deq};
      if (acc_any) begin
        if (acc_last) begin
          lock <= 1'b0;
          prio <= {acc[p_num_reqs-2:0], acc[p_num_reqs-1]};
        end else begin
          lock    <= 1'b1;
          lock_id <= acc_idx;
        end
      end
    end
  end
endmodule
